// File: rtl/lcd_vim828_pkg.sv
// Shared constants, types and helpers for the VIM-828 LCD receive-side decoder.
package lcd_vim828_pkg;

    localparam int unsigned NUM_COM   = 4;
    localparam int unsigned NUM_SEG   = 8;
    localparam int unsigned NUM_DIGIT = 4;
    localparam int unsigned LVL_W     = 2;

    localparam logic [LVL_W-1:0] LVL_0 = 2'd0;
    localparam logic [LVL_W-1:0] LVL_1 = 2'd1;
    localparam logic [LVL_W-1:0] LVL_2 = 2'd2;
    localparam logic [LVL_W-1:0] LVL_3 = 2'd3;

    // Digit bit written by the even / odd SEG line of a digit during COM slot k (index k).
    localparam logic [NUM_COM-1:0][2:0] EBIT = {3'd0, 3'd1, 3'd2, 3'd7};
    localparam logic [NUM_COM-1:0][2:0] OBIT = {3'd5, 3'd6, 3'd4, 3'd3};

    // One complete set of measured line levels for a window.
    typedef struct packed {
        logic [NUM_COM-1:0][LVL_W-1:0] com;
        logic [NUM_SEG-1:0][LVL_W-1:0] seg;
    } level_set_t;

    typedef logic [NUM_DIGIT-1:0][7:0] digits_t;

    // Map a high-sample count within a window of w samples onto one of four levels.
    function automatic logic [LVL_W-1:0] classify(input int unsigned n, input int unsigned w);
        logic [LVL_W-1:0] lvl;
        if (n < w / 6)
            lvl = LVL_0;
        else if (n < w / 2)
            lvl = LVL_1;
        else if (n < (5 * w) / 6)
            lvl = LVL_2;
        else
            lvl = LVL_3;
        return lvl;
    endfunction

endpackage

// File: rtl/lcd_vim828_decoder_meter.sv
// Per-line level meter: synchronise one PWM line, count high samples, classify at window end.
module lcd_level_meter
    import lcd_vim828_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             pwm,
    input  logic             win_end,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_c;

    // Two-flop synchroniser for the asynchronous PWM line.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], pwm};
    end

    // Count including the current cycle's sample.
    assign n_c = cnt + CNT_W'(sync_q[1]);

    // Accumulate high samples; latch the classified level and restart at window end.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt   <= '0;
            level <= LVL_0;
        end else if (win_end) begin
            cnt   <= '0;
            level <= classify(32'(n_c), W);
        end else begin
            cnt   <= n_c;
        end
    end

endmodule

// File: rtl/lcd_vim828_decoder.sv
// VIM-828 LCD receive-side decoder: recovers COM/SEG levels, identifies the active
// COM slot and rebuilds the four pgfedcba digit bytes.
module lcd_vim828_decoder
    import lcd_vim828_pkg::*;
#(
    parameter int unsigned PWM_PERIOD      = 3,
    parameter int unsigned MEASURE_PERIODS = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [3:0]   ComPWM_i,
    input  logic [7:0]   SegPWM_i,
    output logic [7:0]   Digit3_o,
    output logic [7:0]   Digit2_o,
    output logic [7:0]   Digit1_o,
    output logic [7:0]   Digit0_o,
    output logic         Valid_o,
    output logic         Error_o
);

    localparam int unsigned W    = PWM_PERIOD * MEASURE_PERIODS;
    localparam int unsigned WC_W = (W > 1) ? $clog2(W) : 1;

    logic [WC_W-1:0]               win_cnt;
    logic                          win_end_c;
    logic [NUM_COM-1:0][LVL_W-1:0] com_lvl;
    logic [NUM_SEG-1:0][LVL_W-1:0] seg_lvl;
    level_set_t                    cur_c;
    level_set_t                    prev_q;
    logic                          eval_q;
    logic                          act_q;
    logic                          stable_q;
    logic [NUM_COM-1:0]            mask_q;
    digits_t                       shadow_q;
    digits_t                       digits_q;

    logic [NUM_COM-1:0]            h_hit_c;
    logic [NUM_COM-1:0]            l_hit_c;
    logic                          seg_h_ok_c;
    logic                          seg_l_ok_c;
    logic [NUM_SEG-1:0]            seg_on_h_c;
    logic [NUM_SEG-1:0]            seg_on_l_c;
    logic [NUM_SEG-1:0]            seg_on_c;
    logic                          phase_h_c;
    logic                          phase_l_c;
    logic                          legal_c;
    logic [1:0]                    slot_c;
    logic                          cap_c;
    logic                          frame_done_c;
    logic [NUM_COM-1:0]            mask_nxt_c;
    digits_t                       shadow_nxt_c;

    // Free-running measurement window counter shared by all line meters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            win_cnt <= '0;
        else if (win_end_c)
            win_cnt <= '0;
        else
            win_cnt <= win_cnt + WC_W'(1);
    end

    assign win_end_c = (win_cnt == WC_W'(W - 1));

    for (genvar i = 0; i < NUM_COM; i++) begin : g_com
        lcd_level_meter #(.W(W)) u_meter (
            .Clock   (Clock),
            .Reset   (Reset),
            .pwm     (ComPWM_i[i]),
            .win_end (win_end_c),
            .level   (com_lvl[i])
        );
    end

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
        lcd_level_meter #(.W(W)) u_meter (
            .Clock   (Clock),
            .Reset   (Reset),
            .pwm     (SegPWM_i[i]),
            .win_end (win_end_c),
            .level   (seg_lvl[i])
        );
    end

    assign cur_c = {com_lvl, seg_lvl};

    // Compare each fresh level set with the previous window; act on the result one cycle later.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            eval_q   <= 1'b0;
            act_q    <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= '0;
        end else begin
            eval_q <= win_end_c;
            act_q  <= eval_q;
            if (eval_q) begin
                stable_q <= (cur_c == prev_q);
                prev_q   <= cur_c;
            end
        end
    end

    // Pattern decode: find the selected COM slot and the on/off state of every SEG line.
    always_comb begin
        h_hit_c    = '0;
        l_hit_c    = '0;
        seg_h_ok_c = 1'b1;
        seg_l_ok_c = 1'b1;
        seg_on_h_c = '0;
        seg_on_l_c = '0;
        slot_c     = '0;
        for (int k = 0; k < NUM_COM; k++) begin
            h_hit_c[k] = (com_lvl[k] == LVL_3);
            l_hit_c[k] = (com_lvl[k] == LVL_0);
            for (int j = 0; j < NUM_COM; j++) begin
                if (j != k) begin
                    h_hit_c[k] = h_hit_c[k] & (com_lvl[j] == LVL_1);
                    l_hit_c[k] = l_hit_c[k] & (com_lvl[j] == LVL_2);
                end
            end
        end
        for (int s = 0; s < NUM_SEG; s++) begin
            seg_h_ok_c    = seg_h_ok_c & ((seg_lvl[s] == LVL_0) | (seg_lvl[s] == LVL_2));
            seg_l_ok_c    = seg_l_ok_c & ((seg_lvl[s] == LVL_3) | (seg_lvl[s] == LVL_1));
            seg_on_h_c[s] = (seg_lvl[s] == LVL_0);
            seg_on_l_c[s] = (seg_lvl[s] == LVL_3);
        end
        phase_h_c = (|h_hit_c) & seg_h_ok_c;
        phase_l_c = (|l_hit_c) & seg_l_ok_c;
        legal_c   = phase_h_c | phase_l_c;
        seg_on_c  = phase_h_c ? seg_on_h_c : seg_on_l_c;
        for (int k = 0; k < NUM_COM; k++) begin
            if (phase_h_c ? h_hit_c[k] : l_hit_c[k])
                slot_c = 2'(k);
        end
    end

    // Capture into the shadow digits and track which slots have been seen this frame.
    always_comb begin
        cap_c        = act_q & stable_q & legal_c;
        frame_done_c = (mask_q == '1);
        shadow_nxt_c = shadow_q;
        mask_nxt_c   = frame_done_c ? '0 : mask_q;
        if (cap_c) begin
            for (int d = 0; d < NUM_DIGIT; d++) begin
                shadow_nxt_c[d][EBIT[slot_c]] = seg_on_c[2*d];
                shadow_nxt_c[d][OBIT[slot_c]] = seg_on_c[2*d+1];
            end
            mask_nxt_c[slot_c] = 1'b1;
        end
    end

    // Shadow, mask, published digits and the Valid/Error strobes.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shadow_q <= '0;
            mask_q   <= '0;
            digits_q <= '0;
            Valid_o  <= 1'b0;
            Error_o  <= 1'b0;
        end else begin
            shadow_q <= shadow_nxt_c;
            mask_q   <= mask_nxt_c;
            Valid_o  <= frame_done_c;
            Error_o  <= act_q & stable_q & ~legal_c;
            if (frame_done_c)
                digits_q <= shadow_q;
        end
    end

    assign Digit3_o = digits_q[3];
    assign Digit2_o = digits_q[2];
    assign Digit1_o = digits_q[1];
    assign Digit0_o = digits_q[0];

endmodule

// File: tb/tb_lcd_vim828_decoder.sv
// Directed bench for lcd_vim828_decoder: a PWM model of the VIM-828 driver feeds the
// decoder, expected frames go into a scoreboard queue and are compared on Valid_o.
`timescale 1ns/1ps
module tb_lcd_vim828_decoder;

    localparam int SLOT = 100;   // 10 us COM slot at 10 MHz

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] ComPWM_i = '0;
    logic [7:0] SegPWM_i = '0;
    logic [7:0] Digit3_o, Digit2_o, Digit1_o, Digit0_o;
    logic       Valid_o, Error_o;

    logic       m_pwm = 1'b0;
    logic       m_win = 1'b0;
    logic [1:0] m_level;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    int nerr   = 0;
    int ph     = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  com_lvl[4];
    logic [1:0]  seg_lvl[8];
    int ebit[4] = '{7, 2, 1, 0};
    int obit[4] = '{3, 4, 6, 5};

    always #50 Clock = ~Clock;

    lcd_vim828_decoder dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ComPWM_i (ComPWM_i),
        .SegPWM_i (SegPWM_i),
        .Digit3_o (Digit3_o),
        .Digit2_o (Digit2_o),
        .Digit1_o (Digit1_o),
        .Digit0_o (Digit0_o),
        .Valid_o  (Valid_o),
        .Error_o  (Error_o)
    );

    lcd_level_meter #(.W(24)) u_meter (
        .Clock   (Clock),
        .Reset   (Reset),
        .pwm     (m_pwm),
        .win_end (m_win),
        .level   (m_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Valid_o is compared with the frame at the head of the queue.
    always @(negedge Clock) begin
        if (Reset === 1'b1) begin
            if (Valid_o === 1'b1) begin
                nvalid++;
                if (exp_q.size() > 0)
                    chk("frame", {Digit3_o, Digit2_o, Digit1_o, Digit0_o}, exp_q[0]);
            end
            if (Error_o === 1'b1)
                nerr++;
            if (Valid_o === 1'b1 || Error_o === 1'b1)
                chk("valid_error_exclusive", 32'(Valid_o & Error_o), 32'd0);
        end
    end

    // Drive n clock cycles of PWM: level L is high for L of every 3 cycles.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge Clock);
            for (int i = 0; i < 4; i++) ComPWM_i[i] = (int'(com_lvl[i]) > ph);
            for (int i = 0; i < 8; i++) SegPWM_i[i] = (int'(seg_lvl[i]) > ph);
            ph = (ph + 1) % 3;
        end
    endtask

    // Driver levels for COM slot k; pol=0 high phase, pol=1 low phase.
    task automatic set_slot(input int k, input int pol, input logic [31:0] dig);
        logic [7:0] b;
        for (int i = 0; i < 4; i++)
            com_lvl[i] = (i == k) ? (pol != 0 ? 2'd0 : 2'd3) : (pol != 0 ? 2'd2 : 2'd1);
        for (int d = 0; d < 4; d++) begin
            b = dig[8*d +: 8];
            seg_lvl[2*d]   = b[ebit[k]] ? (pol != 0 ? 2'd3 : 2'd0) : (pol != 0 ? 2'd1 : 2'd2);
            seg_lvl[2*d+1] = b[obit[k]] ? (pol != 0 ? 2'd3 : 2'd0) : (pol != 0 ? 2'd1 : 2'd2);
        end
    endtask

    task automatic set_illegal();
        for (int i = 0; i < 4; i++) com_lvl[i] = 2'd1;
        for (int i = 0; i < 8; i++) seg_lvl[i] = 2'd2;
    endtask

    task automatic set_idle();
        for (int i = 0; i < 4; i++) com_lvl[i] = 2'd0;
        for (int i = 0; i < 8; i++) seg_lvl[i] = 2'd0;
    endtask

    task automatic rotation(input logic [31:0] dig, input int rot);
        for (int k = 0; k < 4; k++) begin
            set_slot(k, (k + rot) % 2, dig);
            run(SLOT);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [31:0] exp);
        chk(tag, {Digit3_o, Digit2_o, Digit1_o, Digit0_o}, exp);
    endtask

    initial begin
        int v0, e0;
        int ns[6];
        logic [1:0] ls[6];
        logic [31:0] d1, d2;
        ns = '{3, 4, 11, 12, 19, 20};
        ls = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        d1 = 32'h065B4F66;
        d2 = 32'h12345678;

        // Reset state
        set_idle();
        run(5);
        chk("rst_digit3", 32'(Digit3_o), 32'h0);
        chk("rst_digit2", 32'(Digit2_o), 32'h0);
        chk("rst_digit1", 32'(Digit1_o), 32'h0);
        chk("rst_digit0", 32'(Digit0_o), 32'h0);
        chk("rst_valid",  32'(Valid_o),  32'h0);
        chk("rst_error",  32'(Error_o),  32'h0);
        Reset = 1'b1;

        // Loopback 06 5B 4F 66
        rotation(d1, 0);
        e0 = nerr;
        v0 = nvalid;
        exp_q.push_back(d1);
        rotation(d1, 1);
        rotation(d1, 0);
        chk("loop_valid_seen", 32'(nvalid - v0 >= 1), 32'd1);
        chk("loop_no_error", 32'(nerr - e0), 32'd0);

        // Static illegal levels: errors every stable window, no frame, outputs hold
        set_illegal();
        run(50);
        void'(exp_q.pop_front());
        v0 = nvalid;
        e0 = nerr;
        run(300);
        chk("illegal_errors", 32'(nerr - e0 >= 8), 32'd1);
        chk("illegal_no_valid", 32'(nvalid - v0), 32'd0);
        chk_outputs("illegal_hold", d1);

        // Reset after two captured slots: outputs clear, first frame needs four fresh slots
        set_slot(0, 0, d2); run(SLOT);
        set_slot(1, 1, d2); run(SLOT);
        Reset = 1'b0;
        run(3);
        chk_outputs("midreset_digits", 32'h0);
        chk("midreset_valid", 32'(Valid_o), 32'd0);
        chk("midreset_error", 32'(Error_o), 32'd0);
        Reset = 1'b1;
        v0 = nvalid;
        exp_q.push_back(d2);
        set_slot(0, 0, d2); run(SLOT);
        set_slot(1, 1, d2); run(SLOT);
        set_slot(2, 0, d2); run(SLOT);
        chk("midreset_no_early_valid", 32'(nvalid - v0), 32'd0);
        set_slot(3, 1, d2); run(SLOT);
        set_slot(0, 1, d2); run(SLOT);
        chk("midreset_valid_after_4", 32'(nvalid - v0 >= 1), 32'd1);
        void'(exp_q.pop_front());

        // All segments on, then all off
        rotation(32'hFFFFFFFF, 0);
        e0 = nerr;
        v0 = nvalid;
        exp_q.push_back(32'hFFFFFFFF);
        rotation(32'hFFFFFFFF, 1);
        rotation(32'hFFFFFFFF, 0);
        chk("ff_valid_seen", 32'(nvalid - v0 >= 1), 32'd1);
        chk("ff_colon", 32'(Digit0_o[7]), 32'd1);
        void'(exp_q.pop_front());
        rotation(32'h0, 1);
        v0 = nvalid;
        exp_q.push_back(32'h0);
        rotation(32'h0, 0);
        rotation(32'h0, 1);
        chk("zero_valid_seen", 32'(nvalid - v0 >= 1), 32'd1);
        chk("zero_colon", 32'(Digit0_o[7]), 32'd0);
        chk("ffzero_no_error", 32'(nerr - e0), 32'd0);
        void'(exp_q.pop_front());

        // Only COM0/COM1 slots present: mask never completes
        Reset = 1'b0;
        run(3);
        Reset = 1'b1;
        v0 = nvalid;
        e0 = nerr;
        for (int r = 0; r < 3; r++) begin
            set_slot(0, r % 2, d1); run(SLOT);
            set_slot(1, (r + 1) % 2, d1); run(SLOT);
            set_illegal(); run(2 * SLOT);
        end
        chk("partial_no_valid", 32'(nvalid - v0), 32'd0);
        chk("partial_errors", 32'(nerr - e0 >= 1), 32'd1);
        chk_outputs("partial_digits", 32'h0);

        // Duty sweep on a standalone level meter
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 72; c++) begin
                @(negedge Clock);
                m_pwm = ((c % 24) < ns[i]);
                m_win = ((c % 24) == 23);
            end
            @(negedge Clock);
            m_win = 1'b0;
            chk($sformatf("meter_n%0d", ns[i]), 32'(m_level), 32'(ls[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
